// File: rtl/fsm_modexp_ctrl_if.sv
// Host handshake and MMM strobe bundle for the modular-exponentiation controller.
// The master side is the host register block; the slave side is the controller.
interface fsm_modexp_ctrl_if #(
  parameter int EXP_WIDTH = 8
);
  logic                 ena;
  logic                 start;
  logic                 abort;
  logic [EXP_WIDTH-1:0] exp_e;
  logic                 busy;
  logic                 done;
  logic                 rst_mmm;
  logic                 ld_a;
  logic                 ld_r;
  logic                 lock1;
  logic                 lock2;
  logic [1:0]           sel1;
  logic                 sel2;
  logic                 exp_bit;

  modport master (
    output ena, start, abort, exp_e,
    input  busy, done, rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, exp_bit
  );

  modport slave (
    input  ena, start, abort, exp_e,
    output busy, done, rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, exp_bit
  );
endinterface

// File: rtl/fsm_modexp_ctrl.sv
// Sequencer for Montgomery modular exponentiation: MAP, one MMM pass per exponent
// bit, then REMAP, with start/busy/done handshake, abort and optional leading-zero skip.
module fsm_modexp_ctrl #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8,
  parameter int SKIP_LZ   = 0
) (
  input logic               clk,
  input logic               rst,
  fsm_modexp_ctrl_if.slave  bus
);
  localparam int SW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(EXP_WIDTH + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PRE_MAP    = 4'd1,
    MAP        = 4'd2,
    POST_MAP   = 4'd3,
    PRE_MMM    = 4'd4,
    MMM        = 4'd5,
    POST_MMM   = 4'd6,
    PRE_REMAP  = 4'd7,
    REMAP      = 4'd8,
    POST_REMAP = 4'd9,
    DONE       = 4'd10
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        step_q, step_d;
  logic [RW-1:0]        round_q, round_d;
  logic [RW-1:0]        rounds_q, rounds_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [RW-1:0]        rounds_new;

  logic       busy, done, rst_mmm, ld_a, ld_r, lock1, lock2, sel2, exp_bit;
  logic [1:0] sel1;

  // Round count: full exponent width, or up to and including the highest set bit.
  always_comb begin
    rounds_new = RW'(EXP_WIDTH);
    if (SKIP_LZ != 0) begin
      rounds_new = '0;
      for (int i = 0; i < EXP_WIDTH; i++) begin
        if (bus.exp_e[i]) rounds_new = RW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      round_q  <= '0;
      rounds_q <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      round_q  <= round_d;
      rounds_q <= rounds_d;
      exp_q    <= exp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    round_d  = round_q;
    rounds_d = rounds_q;
    exp_d    = exp_q;
    if (bus.ena) begin
      if (bus.abort) begin
        state_d  = IDLE;
        step_d   = '0;
        round_d  = '0;
        rounds_d = '0;
        exp_d    = '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (bus.start) begin
              state_d  = PRE_MAP;
              exp_d    = bus.exp_e;
              rounds_d = rounds_new;
              step_d   = '0;
              round_d  = '0;
            end
          end
          PRE_MAP:   state_d = MAP;
          PRE_MMM:   state_d = MMM;
          PRE_REMAP: state_d = REMAP;
          // The step counter holds at WIDTH on exit so it never wraps.
          MAP, MMM, REMAP: begin
            if (step_q == STEP_LAST) begin
              state_d = (state_q == MAP) ? POST_MAP :
                        (state_q == MMM) ? POST_MMM : POST_REMAP;
            end else begin
              step_d = step_q + SW'(1);
            end
          end
          POST_MAP: begin
            step_d  = '0;
            state_d = (rounds_q != '0) ? PRE_MMM : PRE_REMAP;
          end
          POST_MMM: begin
            step_d  = '0;
            exp_d   = exp_q >> 1;
            round_d = round_q + RW'(1);
            state_d = (round_q == rounds_q - RW'(1)) ? PRE_REMAP : PRE_MMM;
          end
          POST_REMAP: begin
            step_d  = '0;
            state_d = DONE;
          end
          default: begin
            state_d  = IDLE;
            step_d   = '0;
            round_d  = '0;
            rounds_d = '0;
            exp_d    = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rst_mmm = 1'b0;
    ld_a    = 1'b0;
    ld_r    = 1'b0;
    lock1   = 1'b0;
    lock2   = 1'b0;
    sel1    = 2'b00;
    sel2    = 1'b0;
    case (state_q)
      PRE_MAP, MAP: begin
        busy = 1'b1; rst_mmm = 1'b1; ld_a = 1'b1; lock1 = 1'b1; lock2 = 1'b1;
      end
      POST_MAP: begin
        busy = 1'b1; rst_mmm = 1'b1; ld_r = 1'b1; lock1 = 1'b1; lock2 = 1'b1;
      end
      PRE_MMM, MMM: begin
        busy = 1'b1; rst_mmm = 1'b1; ld_a = (state_q == PRE_MMM);
        lock1 = exp_q[0]; lock2 = 1'b1; sel1 = 2'b01; sel2 = 1'b1;
      end
      POST_MMM: begin
        busy = 1'b1; ld_r = 1'b1; lock1 = exp_q[0]; lock2 = 1'b1;
        sel1 = 2'b01; sel2 = 1'b1;
      end
      PRE_REMAP, REMAP: begin
        busy = 1'b1; rst_mmm = 1'b1; ld_a = (state_q == PRE_REMAP);
        lock1 = 1'b1; sel1 = 2'b10; sel2 = 1'b1;
      end
      POST_REMAP: begin
        busy = 1'b1; ld_r = 1'b1; lock1 = 1'b1; sel1 = 2'b10; sel2 = 1'b1;
      end
      DONE: begin
        done = 1'b1; ld_r = 1'b1; lock1 = 1'b1; sel1 = 2'b10; sel2 = 1'b1;
      end
      default: ;
    endcase
    // Idle and illegal encodings keep every output low, including the exponent tap.
    exp_bit = (busy | done) & exp_q[0];
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rst_mmm = rst_mmm;
  assign bus.ld_a    = ld_a;
  assign bus.ld_r    = ld_r;
  assign bus.lock1   = lock1;
  assign bus.lock2   = lock2;
  assign bus.sel1    = sel1;
  assign bus.sel2    = sel2;
  assign bus.exp_bit = exp_bit;
endmodule

// File: tb/tb_fsm_modexp_ctrl.sv
// Scoreboard bench for fsm_modexp_ctrl: one instance without and one with leading-zero
// skip, driven by directed and random operations, checked by a separate monitor.
module tb_fsm_modexp_ctrl;
  localparam int W  = 8;
  localparam int EW = 8;

  typedef struct {
    int         lat;
    int         raw;
    int         rounds;
    logic [7:0] bits;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ena_v   [2];
  logic       start_v [2];
  logic       abort_v [2];
  logic [7:0] exp_v   [2];
  logic [10:0] outs   [2];

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  fsm_modexp_ctrl_if #(.EXP_WIDTH(EW)) bus0 ();
  fsm_modexp_ctrl_if #(.EXP_WIDTH(EW)) bus1 ();

  assign bus0.ena = ena_v[0];  assign bus0.start = start_v[0];
  assign bus0.abort = abort_v[0];  assign bus0.exp_e = exp_v[0];
  assign bus1.ena = ena_v[1];  assign bus1.start = start_v[1];
  assign bus1.abort = abort_v[1];  assign bus1.exp_e = exp_v[1];

  // Output vector: busy,done,rst_mmm,ld_a,ld_r,lock1,lock2,sel1[1:0],sel2,exp_bit
  assign outs[0] = {bus0.busy, bus0.done, bus0.rst_mmm, bus0.ld_a, bus0.ld_r,
                    bus0.lock1, bus0.lock2, bus0.sel1, bus0.sel2, bus0.exp_bit};
  assign outs[1] = {bus1.busy, bus1.done, bus1.rst_mmm, bus1.ld_a, bus1.ld_r,
                    bus1.lock1, bus1.lock2, bus1.sel1, bus1.sel2, bus1.exp_bit};

  fsm_modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .SKIP_LZ(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  fsm_modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .SKIP_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int rounds_of(input logic [7:0] e, input bit skip);
    if (!skip) return EW;
    for (int b = EW - 1; b >= 0; b--) if (e[b]) return b + 1;
    return 0;
  endfunction

  function automatic exp_t model(input logic [7:0] e, input bit skip, input int stalls);
    exp_t x;
    x.rounds = rounds_of(e, skip);
    x.lat    = (W + 3) * (x.rounds + 2);
    x.raw    = x.lat + stalls;
    x.bits   = 8'((16'(e) & ((16'd1 << x.rounds) - 16'd1)));
    return x;
  endfunction

  task automatic sb_push(input int i, input exp_t x);
    if (i == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic sb_drop(input int i);
    exp_t x;
    if (i == 0) begin if (q0.size() > 0) x = q0.pop_back(); end
    else begin if (q1.size() > 0) x = q1.pop_back(); end
  endtask

  // One operation on instance i; event offsets count enabled edges after the accept edge.
  task automatic applyStimulus(input int i, input logic [7:0] e, input int stall_at,
                               input int stall_len, input int abort_at,
                               input int pulse_at, input int rst_at);
    exp_t        x;
    int          cnt;
    int          guard;
    logic [10:0] snap;
    x = model(e, i == 1, (stall_at >= 0) ? stall_len : 0);
    @(negedge clk);
    ena_v[i] = 1'b1; start_v[i] = 1'b1; exp_v[i] = e;
    sb_push(i, x);
    @(negedge clk);
    start_v[i] = 1'b0; exp_v[i] = 8'($urandom);
    checkOutput("busy_after_start", 32'(outs[i][10]), 32'd1);
    cnt = 0; guard = 0;
    while (!outs[i][9] && guard < 4 * x.lat + 50) begin
      if (cnt == abort_at) begin
        abort_v[i] = 1'b1;
        @(negedge clk);
        abort_v[i] = 1'b0;
        checkOutput("abort_to_idle", 32'(outs[i]), 32'd0);
        sb_drop(i);
        return;
      end
      if (cnt == rst_at) begin
        #2 rst = 1'b1;
        #1 checkOutput("rst_async_outs", 32'(outs[i]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_drop(i);
        @(negedge clk);
        checkOutput("rst_release_idle", 32'(outs[i]), 32'd0);
        return;
      end
      if (cnt == stall_at) begin
        snap = outs[i];
        ena_v[i] = 1'b0;
        repeat (stall_len) @(negedge clk);
        checkOutput("stall_frozen", 32'(outs[i]), 32'(snap));
        ena_v[i] = 1'b1;
      end
      if (cnt == pulse_at) begin
        start_v[i] = 1'b1; exp_v[i] = ~e;
      end
      @(negedge clk);
      start_v[i] = 1'b0;
      cnt++; guard++;
    end
    checkOutput("done_within_bound", 32'(outs[i][9]), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("done_held", 32'(outs[i][9]), 32'd1);
  endtask

  // Monitor: rebuilds each operation's latency, round count and per-round lock1/exp_bit.
  initial begin : monitor
    automatic int         cyc [2];
    automatic int         raw [2];
    automatic int         rseen [2];
    automatic logic [7:0] lock_pat [2];
    automatic logic [7:0] bit_pat [2];
    automatic bit         active [2];
    automatic bit         p_busy [2];
    automatic bit         p_done [2];
    automatic bit         p_post [2];
    automatic bit         saw01 [2];
    automatic logic       en [2];
    automatic logic [10:0] o;
    automatic bit         post;
    exp_t                 x;
    for (int i = 0; i < 2; i++) begin
      active[i] = 0; p_busy[i] = 0; p_done[i] = 0; p_post[i] = 0;
    end
    forever begin
      @(posedge clk);
      en[0] = ena_v[0]; en[1] = ena_v[1];
      #1;
      for (int i = 0; i < 2; i++) begin
        o = outs[i];
        if (rst) begin
          active[i] = 0; p_busy[i] = 0; p_done[i] = 0; p_post[i] = 0;
          continue;
        end
        if (o[10] && !p_busy[i]) begin
          active[i] = 1; cyc[i] = 0; raw[i] = 0; rseen[i] = 0;
          lock_pat[i] = '0; bit_pat[i] = '0; saw01[i] = 0;
        end else if (active[i]) begin
          raw[i]++;
          if (en[i]) cyc[i]++;
        end
        post = o[6] && (o[3:2] == 2'b01);
        if (active[i]) begin
          if (o[3:2] == 2'b01) saw01[i] = 1;
          if (post && !p_post[i]) begin
            if (rseen[i] < 8) begin
              lock_pat[i][rseen[i]] = o[5];
              bit_pat[i][rseen[i]]  = o[0];
            end
            rseen[i]++;
          end
          if (o[9] && !p_done[i]) begin
            checkOutput("sb_pending", 32'((i == 0) ? q0.size() : q1.size()) != 32'd0, 32'd1);
            if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
              x = (i == 0) ? q0.pop_front() : q1.pop_front();
              checkOutput("latency_enabled", 32'(cyc[i]), 32'(x.lat));
              checkOutput("latency_raw", 32'(raw[i]), 32'(x.raw));
              checkOutput("round_count", 32'(rseen[i]), 32'(x.rounds));
              checkOutput("lock1_pattern", 32'(lock_pat[i]), 32'(x.bits));
              checkOutput("exp_bit_pattern", 32'(bit_pat[i]), 32'(x.bits));
              checkOutput("mmm_visited", 32'(saw01[i]), 32'(x.rounds > 0));
            end
            active[i] = 0;
          end else if (!o[10] && !o[9]) begin
            active[i] = 0;
          end
        end
        p_busy[i] = o[10]; p_done[i] = o[9]; p_post[i] = post;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin : stimulus
    int         r;
    int         lat;
    int         mode;
    logic [7:0] e;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ena_v[i] = 1'b1; start_v[i] = 1'b0; abort_v[i] = 1'b0; exp_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_outs_0", 32'(outs[0]), 32'd0);
    checkOutput("reset_outs_1", 32'(outs[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(0, 8'hA5, -1, 0, -1, -1, -1);
    applyStimulus(0, 8'hA5, -1, 0, (W + 3) * 4 + 5, -1, -1);
    applyStimulus(0, 8'hA5, -1, 0, -1, -1, -1);
    applyStimulus(0, 8'hA5, (W + 3) * 9 + 3, 5, -1, 20, -1);
    applyStimulus(0, 8'h3C, -1, 0, -1, -1, 30);
    applyStimulus(0, 8'h5A, -1, 0, -1, -1, -1);
    applyStimulus(0, 8'hFF, -1, 0, -1, -1, -1);
    applyStimulus(1, 8'h05, -1, 0, -1, -1, -1);
    applyStimulus(1, 8'h00, -1, 0, -1, -1, -1);
    applyStimulus(1, 8'h80, -1, 0, -1, 7, -1);

    $display("[TB] random operations");
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 2; i++) begin
        e    = 8'($urandom);
        r    = rounds_of(e, i == 1);
        lat  = (W + 3) * (r + 2);
        mode = int'($urandom_range(0, 3));
        case (mode)
          1: applyStimulus(i, e, int'($urandom_range(0, lat - 1)), int'($urandom_range(1, 6)),
                           -1, int'($urandom_range(0, lat - 1)), -1);
          2: applyStimulus(i, e, -1, 0, int'($urandom_range(0, lat - 1)), -1, -1);
          3: applyStimulus(i, e, -1, 0, -1, int'($urandom_range(0, lat - 1)), -1);
          default: applyStimulus(i, e, -1, 0, -1, -1, -1);
        endcase
      end
    end
    repeat (4) @(negedge clk);
    checkOutput("sb_drained_0", 32'(q0.size()), 32'd0);
    checkOutput("sb_drained_1", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fsm_modexp_ctrl.md
# fsm_modexp_ctrl

- Parametrised control FSM for the Montgomery modular-exponentiation datapath. It sequences MAP, then one MMM pass per exponent bit, then REMAP, driving the MMM reset, load, lock and mux-select strobes.
- Successor to the fixed-width controller. It adds independent operand and exponent widths, an optional leading-zero skip mode, and a start/busy/done handshake with abort and restart.
- Sits between the host register block and the MMM datapath.

## Interface
Parameters:
- WIDTH, default 8: operand width; each MMM pass lasts WIDTH+1 cycles.
- EXP_WIDTH, default 8: exponent width; maximum number of rounds.
- SKIP_LZ, default 0: 1 skips the exponent's leading zero bits.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- rst  input  1  asynchronous active-high reset.
- ena  input  1  clock enable; 0 freezes state, counters and exponent register.
- start  input  1  begin operation; sampled in IDLE or DONE when ena=1.
- abort  input  1  cancel operation; return to IDLE.
- exp_e  input  EXP_WIDTH  exponent, captured when start is accepted.
- busy  output  1  operation in progress.
- done  output  1  result valid; held until start, abort or rst.
- rst_mmm  output  1  MMM reset, active-low (0 holds MMM in reset).
- ld_a  output  1  load operand register A.
- ld_r  output  1  load result register.
- lock1  output  1  multiply-path enable (current exponent bit during MMM).
- lock2  output  1  square-path enable.
- sel1  output  2  operand mux: 00 map, 01 exponentiate, 10 remap.
- sel2  output  1  B-operand mux.
- exp_bit  output  1  current LSB of the exponent shift register.

## Operation
- All outputs are a combinational decode of the state register, except lock1 and exp_bit, which also depend on reg_exp[0].
- States: IDLE, PRE_MAP, MAP, POST_MAP, PRE_MMM, MMM, POST_MMM, PRE_REMAP, REMAP, POST_REMAP, DONE.
- IDLE: all outputs 0.
  - start → PRE_MAP.
  - On the same edge: reg_exp←exp_e, R←round count, step_cnt←0, round_cnt←0.
- Round count R:
  - SKIP_LZ=0: R=EXP_WIDTH.
  - SKIP_LZ=1: R = (index of the MSB set in exp_e) + 1, and R=0 when exp_e=0.
- Counters:
  - step_cnt is $clog2(WIDTH+1) bits. It increments in MAP, MMM and REMAP, and clears in every POST_* state.
  - round_cnt is $clog2(EXP_WIDTH+1) bits. It increments in POST_MMM.
  - Neither counter wraps within an operation.
- Per-state output decode (outputs not listed are 0):
  - PRE_MAP: rst_mmm=1, ld_a=1, lock1=1, lock2=1, sel1=00. Next state MAP.
  - MAP: as PRE_MAP. Exits to POST_MAP when step_cnt==WIDTH.
  - POST_MAP: rst_mmm=1, ld_r=1, lock1=1, lock2=1. Next state PRE_MMM if R>0, else PRE_REMAP.
  - PRE_MMM: rst_mmm=1, ld_a=1, lock1=reg_exp[0], lock2=1, sel1=01, sel2=1.
  - MMM: as PRE_MMM but ld_a=0. Exits to POST_MMM when step_cnt==WIDTH.
  - POST_MMM: ld_r=1, lock1=reg_exp[0], lock2=1, sel1=01, sel2=1. reg_exp shifts right by 1. Next state PRE_REMAP if round_cnt==R-1, else PRE_MMM.
  - PRE_REMAP: rst_mmm=1, ld_a=1, lock1=1, lock2=0, sel1=10, sel2=1.
  - REMAP: as PRE_REMAP but ld_a=0. Exits to POST_REMAP when step_cnt==WIDTH.
  - POST_REMAP: ld_r=1, lock1=1, sel1=10, sel2=1. Next state DONE.
  - DONE: as POST_REMAP, plus done=1.
- DONE exits:
  - start → PRE_MAP, with a fresh capture of exp_e.
  - abort → IDLE.
- busy=1 in every state except IDLE and DONE.
- start while busy is ignored.
- abort (with ena=1) in any state: next state IDLE, counters and reg_exp cleared. abort has priority over start.
- Unreachable state encodings decode to IDLE outputs and return to IDLE.

## Timing
- Reset is asynchronous: on rst, state becomes IDLE immediately, counters and reg_exp are 0, and all outputs are 0. Reset deassertion is synchronous to clk.
- Each MAP, MMM or REMAP phase lasts WIDTH+1 cycles; each PRE_*/POST_* state lasts 1 cycle.
- Latency: done rises (WIDTH+3)·(R+2) enabled cycles after the clk edge that accepts start.
- exp_bit is valid for the whole PRE_MMM/MMM/POST_MMM sequence of round k, and equals bit k of the captured exponent.
- ena=0 stalls all sequential elements for that cycle. Outputs hold, and latency grows by exactly the number of stalled cycles.
- Asserting rst mid-operation aborts immediately; there is no done pulse.

## Test plan
- WIDTH=8, EXP_WIDTH=8, SKIP_LZ=0, exp_e=0xA5, start 1 cycle → busy next cycle; done at cycle 110. lock1 during rounds 0..7 is 1,0,1,0,0,1,0,1.
- SKIP_LZ=1, exp_e=0x05 → R=3; done at cycle 55; exactly 3 POST_MMM ld_r pulses.
- SKIP_LZ=1, exp_e=0x00 → R=0; no MMM state visited; done at cycle 22; sel1 goes 00 then 10.
- abort asserted in MMM of round 3 → IDLE next cycle with all outputs 0. A following start with the same exponent gives the full 110-cycle latency.
- ena held low 5 cycles during REMAP → outputs frozen; done at cycle 115. start pulsed while busy has no effect.
- rst pulsed during MMM → all outputs 0 within the same cycle (asynchronous). After release, done=0 and state is IDLE. start from DONE restarts with a new exp_e=0xFF (8 rounds, lock1 always 1).
